// File: rtl/scr1_dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// scr1_dmem_responder_pkg : memory-interface types and helpers for the responder
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package scr1_dmem_responder_pkg;

  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;

  typedef enum logic [1:0] {
    SCR1_MEM_CMD_RD    = 2'd0,
    SCR1_MEM_CMD_WR    = 2'd1,
    SCR1_MEM_CMD_ERROR = 2'd2
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'd0,
    SCR1_MEM_WIDTH_HWORD = 2'd1,
    SCR1_MEM_WIDTH_WORD  = 2'd2,
    SCR1_MEM_WIDTH_ERROR = 2'd3
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_IDLE = 2'd0,
    SCR1_MEM_RESP_RDY  = 2'd1,
    SCR1_MEM_RESP_ER   = 2'd2
  } type_scr1_mem_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_resp_state_e;

  function automatic logic [3:0] be_decode(input type_scr1_mem_width_e width,
                                           input logic [1:0]           offs);
    case (width)
      SCR1_MEM_WIDTH_BYTE:  be_decode = 4'b0001 << offs;
      SCR1_MEM_WIDTH_HWORD: be_decode = 4'b0011 << offs;
      SCR1_MEM_WIDTH_WORD:  be_decode = 4'b1111;
      default:              be_decode = 4'b0000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/scr1_dmem_resp_array.sv
// -----------------------------------------------------------------------------
// scr1_dmem_resp_array : word RAM, byte write enables, registered read port
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module scr1_dmem_resp_array #(
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = 12
) (
  input  logic             clk,
  input  logic [3:0]       we_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [0:DEPTH_WORDS-1];
  logic [31:0] rdata_q;

  // No reset so the storage maps onto an SRAM macro; read data holds until the next read.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    if (re_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/scr1_dmem_responder.sv
// -----------------------------------------------------------------------------
// scr1_dmem_responder : SCR1 data-memory target with fixed response latency
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module scr1_dmem_responder
  import scr1_dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          RESP_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        dmem_req_i,
  input  type_scr1_mem_cmd_e          dmem_cmd_i,
  input  type_scr1_mem_width_e        dmem_width_i,
  input  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr_i,
  input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata_i,
  output logic                        dmem_req_ack_o,
  output logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata_o,
  output type_scr1_mem_resp_e         dmem_resp_o
);

  localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [1:0]  CNT_INIT = 2'(RESP_LATENCY - 2);

  dmem_resp_state_e state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             err_q, rd_q;
  logic [1:0]       shift_q;

  logic        accept;
  logic [31:0] offs;
  logic        err;
  logic [3:0]  we;
  logic        re;
  logic [31:0] wdata_rep;
  logic [31:0] arr_rdata;

  assign dmem_req_ack_o = (state_q != ST_WAIT);
  assign accept         = dmem_req_i & dmem_req_ack_o;

  // Unsigned offset makes addresses below BASE_ADDR wrap into the out-of-range region.
  assign offs = dmem_addr_i - BASE_ADDR;
  assign err  = ((dmem_cmd_i != SCR1_MEM_CMD_RD) && (dmem_cmd_i != SCR1_MEM_CMD_WR))
              || (dmem_width_i == SCR1_MEM_WIDTH_ERROR)
              || ((dmem_width_i == SCR1_MEM_WIDTH_HWORD) && dmem_addr_i[0])
              || ((dmem_width_i == SCR1_MEM_WIDTH_WORD) && (dmem_addr_i[1:0] != 2'b00))
              || ({1'b0, offs} >= SPAN);

  assign we = (accept && !err && (dmem_cmd_i == SCR1_MEM_CMD_WR))
            ? be_decode(dmem_width_i, dmem_addr_i[1:0]) : 4'b0000;
  assign re = accept && !err && (dmem_cmd_i == SCR1_MEM_CMD_RD);

  always_comb begin
    wdata_rep = dmem_wdata_i;
    case (dmem_width_i)
      SCR1_MEM_WIDTH_BYTE:  wdata_rep = {4{dmem_wdata_i[7:0]}};
      SCR1_MEM_WIDTH_HWORD: wdata_rep = {2{dmem_wdata_i[15:0]}};
      default:              wdata_rep = dmem_wdata_i;
    endcase
  end

  scr1_dmem_resp_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .we_i    (we),
    .re_i    (re),
    .idx_i   (offs[IDX_W+1:2]),
    .wdata_i (wdata_rep),
    .rdata_o (arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 2'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: begin
        if (accept) begin
          if (RESP_LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      shift_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        err_q   <= err;
        rd_q    <= (dmem_cmd_i == SCR1_MEM_CMD_RD);
        shift_q <= dmem_addr_i[1:0];
      end
    end
  end

  always_comb begin
    dmem_resp_o  = SCR1_MEM_RESP_IDLE;
    dmem_rdata_o = '0;
    if (state_q == ST_RESP) begin
      dmem_resp_o = err_q ? SCR1_MEM_RESP_ER : SCR1_MEM_RESP_RDY;
      if (!err_q && rd_q) dmem_rdata_o = arr_rdata >> {shift_q, 3'b000};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_scr1_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_scr1_dmem_responder : scoreboard bench over three responder configurations
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_scr1_dmem_responder;
  import scr1_dmem_responder_pkg::*;

  typedef struct {
    int                  d;
    type_scr1_mem_resp_e resp;
    logic [31:0]         rdata;
    int                  cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  exp_t sbq[$];

  logic                 rst_n [3];
  logic                 req   [3];
  type_scr1_mem_cmd_e   cmd   [3];
  type_scr1_mem_width_e width [3];
  logic [31:0]          addr  [3];
  logic [31:0]          wdata [3];
  logic                 ack   [3];
  logic [31:0]          rdata [3];
  type_scr1_mem_resp_e  resp  [3];

  // dut0: L=1, 4096 words @0; dut1: L=3, 16 words @0x1000; dut2: L=4, 16 words @0
  for (genvar i = 0; i < 3; i++) begin : g_dut
    scr1_dmem_responder #(
      .DEPTH_WORDS  ((i == 0) ? 4096 : 16),
      .BASE_ADDR    ((i == 1) ? 32'h0000_1000 : 32'h0000_0000),
      .RESP_LATENCY ((i == 0) ? 1 : (i == 1) ? 3 : 4)
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n[i]),
      .dmem_req_i     (req[i]),
      .dmem_cmd_i     (cmd[i]),
      .dmem_width_i   (width[i]),
      .dmem_addr_i    (addr[i]),
      .dmem_wdata_i   (wdata[i]),
      .dmem_req_ack_o (ack[i]),
      .dmem_rdata_o   (rdata[i]),
      .dmem_resp_o    (resp[i])
    );
  end

  function automatic int lat_of(input int d);
    lat_of = (d == 0) ? 1 : (d == 1) ? 3 : 4;
  endfunction

  // Monitor: every non-IDLE response must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (resp[d] != SCR1_MEM_RESP_IDLE) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_resp dut=%0d cyc=%0d got resp=%0d rdata=%h need none",
                   d, cyc, resp[d], rdata[d]);
        end else begin
          e = sbq.pop_front();
          if (e.d != d || e.resp != resp[d] || e.rdata != rdata[d] || e.cyc != cyc) begin
            bad++;
            $display("FAIL resp_check dut=%0d got resp=%0d rdata=%h cyc=%0d need dut=%0d resp=%0d rdata=%h cyc=%0d",
                     d, resp[d], rdata[d], cyc, e.d, e.resp, e.rdata, e.cyc);
          end
        end
      end else if (rdata[d] != 32'h0) begin
        total++;
        bad++;
        $display("FAIL idle_rdata dut=%0d got %h need 0", d, rdata[d]);
      end
    end
    if (rst_n[0] && !ack[0]) begin
      total++;
      bad++;
      $display("FAIL ack_l1 got 0 need 1 at cyc=%0d", cyc);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input int d, input type_scr1_mem_cmd_e c,
                       input type_scr1_mem_width_e w, input logic [31:0] a,
                       input logic [31:0] wd, input type_scr1_mem_resp_e er,
                       input logic [31:0] erd, input bit expect_resp);
    int n;
    n = 0;
    req[d]   = 1'b1;
    cmd[d]   = c;
    width[d] = w;
    addr[d]  = a;
    wdata[d] = wd;
    while (!ack[d] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (!ack[d]) begin
      bad++;
      $display("FAIL ack_timeout dut=%0d got ack=0 need ack=1 within 20 cycles", d);
    end else if (expect_resp) begin
      sbq.push_back(exp_t'{d, er, erd, cyc + lat_of(d)});
    end
    @(posedge clk);
    #1;
    req[d] = 1'b0;
  endtask

  task automatic check_quiet(input int d, input string tag);
    total++;
    if (resp[d] != SCR1_MEM_RESP_IDLE || rdata[d] != 32'h0 || ack[d] != 1'b1) begin
      bad++;
      $display("FAIL %s dut=%0d got resp=%0d rdata=%h ack=%0d need resp=0 rdata=0 ack=1",
               tag, d, resp[d], rdata[d], ack[d]);
    end
  endtask

  initial begin
    logic [6:0] pat;
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b1;
      req[d]   = 1'b0;
      cmd[d]   = SCR1_MEM_CMD_RD;
      width[d] = SCR1_MEM_WIDTH_WORD;
      addr[d]  = 32'h0;
      wdata[d] = 32'h0;
    end
    #2;
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) check_quiet(d, "reset_in");
    idle(3);
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
    idle(1);
    for (int d = 0; d < 3; d++) check_quiet(d, "reset_out");

    // L=1: back-to-back accesses, byte/halfword lanes, error cases, range edge
    issue(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h10, 32'hDEADBEEF, SCR1_MEM_RESP_RDY, 32'h0, 1);
    issue(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h10, 32'h0, SCR1_MEM_RESP_RDY, 32'hDEADBEEF, 1);
    issue(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE,  32'h13, 32'h000000A5, SCR1_MEM_RESP_RDY, 32'h0, 1);
    issue(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h10, 32'h0, SCR1_MEM_RESP_RDY, 32'hA5ADBEEF, 1);
    issue(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h12, 32'h0, SCR1_MEM_RESP_RDY, 32'h0000A5AD, 1);
    issue(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE,  32'h13, 32'h0, SCR1_MEM_RESP_RDY, 32'h000000A5, 1);
    issue(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE,  32'h11, 32'h0, SCR1_MEM_RESP_RDY, 32'h00A5ADBE, 1);
    issue(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h11, 32'h00001234, SCR1_MEM_RESP_ER, 32'h0, 1);
    issue(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h12, 32'h55555555, SCR1_MEM_RESP_ER, 32'h0, 1);
    issue(0, SCR1_MEM_CMD_ERROR, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h66666666, SCR1_MEM_RESP_ER, 32'h0, 1);
    issue(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_ERROR, 32'h10, 32'h77777777, SCR1_MEM_RESP_ER, 32'h0, 1);
    issue(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h10, 32'h0, SCR1_MEM_RESP_RDY, 32'hA5ADBEEF, 1);
    issue(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h4000, 32'h0, SCR1_MEM_RESP_ER, 32'h0, 1);
    issue(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h3FFC, 32'h0BADF00D, SCR1_MEM_RESP_RDY, 32'h0, 1);
    issue(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h3FFC, 32'h0, SCR1_MEM_RESP_RDY, 32'h0BADF00D, 1);
    idle(3);

    // L=3, BASE=0x1000: wrap-around range check, upper halfword lane, ack pattern
    issue(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h1000, 32'h11111111, SCR1_MEM_RESP_RDY, 32'h0, 1);
    issue(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h0000, 32'h0, SCR1_MEM_RESP_ER, 32'h0, 1);
    issue(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h1040, 32'h0, SCR1_MEM_RESP_ER, 32'h0, 1);
    issue(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h103E, 32'h0000CAFE, SCR1_MEM_RESP_RDY, 32'h0, 1);
    issue(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h103E, 32'h0, SCR1_MEM_RESP_RDY, 32'h0000CAFE, 1);
    idle(5);
    pat      = 7'b1001001;
    req[1]   = 1'b1;
    cmd[1]   = SCR1_MEM_CMD_RD;
    width[1] = SCR1_MEM_WIDTH_WORD;
    addr[1]  = 32'h1000;
    for (int i = 0; i < 7; i++) begin
      total++;
      if (ack[1] !== pat[i]) begin
        bad++;
        $display("FAIL ack_pattern step=%0d got %0d need %0d", i, ack[1], pat[i]);
      end
      if (ack[1]) sbq.push_back(exp_t'{1, SCR1_MEM_RESP_RDY, 32'h11111111, cyc + 3});
      @(posedge clk);
      #1;
    end
    req[1] = 1'b0;
    idle(5);

    // L=4: reset while a read is outstanding drops its response
    issue(2, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h8, 32'h12345678, SCR1_MEM_RESP_RDY, 32'h0, 1);
    issue(2, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h8, 32'h0, SCR1_MEM_RESP_IDLE, 32'h0, 0);
    idle(1);
    rst_n[2] = 1'b0;
    idle(1);
    rst_n[2] = 1'b1;
    #1;
    total++;
    if (g_dut[2].u_dut.state_q != ST_IDLE) begin
      bad++;
      $display("FAIL rst_state got %0d need %0d", g_dut[2].u_dut.state_q, ST_IDLE);
    end
    check_quiet(2, "rst_mid");
    idle(6);
    issue(2, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h8, 32'h0, SCR1_MEM_RESP_RDY, 32'h12345678, 1);
    idle(8);

    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL pending_resp got %0d outstanding need 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
